// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory signal bundle for mem_access_unit.
// slave: the load/store unit; master: the CPU datapath plus data memory that surround it.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_done;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_read_control;
  logic        write_data_control;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_done, resp_rdata, resp_err,
    output mem_addr, mem_read_control, write_data_control, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_done, resp_rdata, resp_err,
    input  mem_addr, mem_read_control, write_data_control, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store unit in front of a word-indexed data memory.
// Define MEM_ACCESS_MISALIGN_EN to reject misaligned halfword/word accesses.
module mem_access_unit #(
  parameter int unsigned DEPTH = 128
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e      state_q, state_d;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] buf_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_err;
  logic [31:0] load_shift;
  logic [31:0] load_data;
  logic [31:0] merged;

  always_comb begin
    req_err = (bus.req_size == 2'b11) || ({2'b00, bus.req_addr[31:2]} >= DEPTH);
`ifdef MEM_ACCESS_MISALIGN_EN
    if ((bus.req_size == 2'b01) && bus.req_addr[0]) req_err = 1'b1;
    if ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00)) req_err = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (req_err) begin
            state_d = StDone;
          end else if (bus.req_write && (bus.req_size == 2'b10)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd:    state_d = write_q ? StWr : StDone;
      StWr:    state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Low offset bits beyond the access size are ignored, which forces alignment.
  always_comb begin
    unique case (size_q)
      2'b00:   load_shift = bus.mem_rdata >> {addr_q[1:0], 3'b000};
      2'b01:   load_shift = bus.mem_rdata >> {addr_q[1], 4'b0000};
      default: load_shift = bus.mem_rdata;
    endcase
    unique case (size_q)
      2'b00:   load_data = {{24{signed_q & load_shift[7]}}, load_shift[7:0]};
      2'b01:   load_data = {{16{signed_q & load_shift[15]}}, load_shift[15:0]};
      default: load_data = load_shift;
    endcase
  end

  always_comb begin
    merged = buf_q;
    unique case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  assign bus.req_ready          = (state_q == StIdle);
  assign bus.resp_done          = (state_q == StDone);
  assign bus.resp_err           = (state_q == StDone) && err_q;
  assign bus.resp_rdata         = rdata_q;
  assign bus.mem_addr           = {2'b00, addr_q[31:2]};
  // Gated by rst so a reset landing mid-transaction can never commit a write.
  assign bus.mem_read_control   = (state_q == StRd) && !rst;
  assign bus.write_data_control = (state_q == StWr) && !rst;
  assign bus.mem_wdata          = (state_q == StWr) ? merged : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      buf_q    <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && bus.req_valid) begin
        write_q  <= bus.req_write;
        size_q   <= bus.req_size;
        signed_q <= bus.req_signed;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        err_q    <= req_err;
      end
      if (state_q == StRd) begin
        buf_q <= bus.mem_rdata;
        if (!write_q) rdata_q <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural data memory.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst;
  logic preload;
  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit #(.DEPTH(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [31:0] mem [128];
  int          wr_count;
  logic [31:0] wr_addr_log;
  logic [31:0] wr_data_log;

  assign bus.mem_rdata = (bus.mem_addr < 32'd128) ? mem[bus.mem_addr[6:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
      mem[1]      <= 32'd2;
      mem[2]      <= 32'd5;
      wr_count    <= 0;
      wr_addr_log <= 32'h0;
      wr_data_log <= 32'h0;
    end else if (bus.write_data_control) begin
      if (bus.mem_addr < 32'd128) mem[bus.mem_addr[6:0]] <= bus.mem_wdata;
      wr_count    <= wr_count + 1;
      wr_addr_log <= bus.mem_addr;
      wr_data_log <= bus.mem_wdata;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, then follow it to its done pulse counting edges and memory strobes.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic err, output logic [31:0] rd,
                         output int nrd, output int nwr);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    // Scramble the request fields so the unit must rely on its latched copy.
    bus.req_valid  = 1'b0;
    bus.req_write  = ~w;
    bus.req_signed = ~sg;
    bus.req_addr   = 32'hFFFF_FFFC;
    bus.req_wdata  = 32'h5A5A_5A5A;
    check("busy_ready", {31'b0, bus.req_ready}, 32'd0);
    lat = 1;
    nrd = 0;
    nwr = 0;
    while (!bus.resp_done && lat < 8) begin
      if (bus.mem_read_control) nrd++;
      if (bus.write_data_control) nwr++;
      @(posedge clk);
      #1;
      lat++;
    end
    check("done_seen", {31'b0, bus.resp_done}, 32'd1);
    err = bus.resp_err;
    rd  = bus.resp_rdata;
    @(posedge clk);
    #1;
    check("done_one_cycle", {31'b0, bus.resp_done}, 32'd0);
    check("ready_after_done", {31'b0, bus.req_ready}, 32'd1);
  endtask

  int          lat;
  logic        err;
  logic [31:0] rd;
  int          nrd;
  int          nwr;
  int          wr_before;

  initial begin
    rst            = 1'b1;
    preload        = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_done", {31'b0, bus.resp_done}, 32'd0);
    check("rst_err", {31'b0, bus.resp_err}, 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_rd_ctl", {31'b0, bus.mem_read_control}, 32'd0);
    check("rst_wr_ctl", {31'b0, bus.write_data_control}, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'h0);
    @(negedge clk);
    rst     = 1'b0;
    preload = 1'b0;

    // Word load from mem[1]
    run_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, err, rd, nrd, nwr);
    check("wload_lat", lat, 32'd2);
    check("wload_data", rd, 32'h0000_0002);
    check("wload_err", {31'b0, err}, 32'd0);
    check("wload_nrd", nrd, 32'd1);
    check("wload_nwr", nwr, 32'd0);

    // Byte store 0xAB into lane 1 of mem[2]
    run_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_00AB, lat, err, rd, nrd, nwr);
    check("bstore_lat", lat, 32'd3);
    check("bstore_nrd", nrd, 32'd1);
    check("bstore_nwr", nwr, 32'd1);
    check("bstore_err", {31'b0, err}, 32'd0);
    check("bstore_waddr", wr_addr_log, 32'd2);
    check("bstore_wdata", wr_data_log, 32'h0000_AB05);

    run_req(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, lat, err, rd, nrd, nwr);
    check("ubload_data", rd, 32'h0000_00AB);
    check("ubload_lat", lat, 32'd2);
    run_req(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, lat, err, rd, nrd, nwr);
    check("sbload_data", rd, 32'hFFFF_FFAB);

    // Halfword store into upper lane of mem[2]
    run_req(1'b1, 2'b01, 1'b0, 32'hA, 32'h0000_8001, lat, err, rd, nrd, nwr);
    check("hstore_lat", lat, 32'd3);
    check("hstore_mem2", mem[2], 32'h8001_AB05);
    run_req(1'b0, 2'b01, 1'b1, 32'hA, 32'h0, lat, err, rd, nrd, nwr);
    check("shload_hi", rd, 32'hFFFF_8001);
    run_req(1'b0, 2'b01, 1'b1, 32'h8, 32'h0, lat, err, rd, nrd, nwr);
    check("shload_lo", rd, 32'hFFFF_AB05);
    run_req(1'b0, 2'b01, 1'b0, 32'h8, 32'h0, lat, err, rd, nrd, nwr);
    check("uhload_lo", rd, 32'h0000_AB05);
    run_req(1'b0, 2'b10, 1'b1, 32'h8, 32'h0, lat, err, rd, nrd, nwr);
    check("wload_mem2", rd, 32'h8001_AB05);

    // Out-of-range index and reserved size
    run_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, lat, err, rd, nrd, nwr);
    check("oor_lat", lat, 32'd1);
    check("oor_err", {31'b0, err}, 32'd1);
    check("oor_nrd", nrd, 32'd0);
    run_req(1'b1, 2'b10, 1'b0, 32'h1FC, 32'h1111_2222, lat, err, rd, nrd, nwr);
    check("last_word_err", {31'b0, err}, 32'd0);
    check("last_word_mem", mem[127], 32'h1111_2222);
    wr_before = wr_count;
    run_req(1'b1, 2'b11, 1'b0, 32'h4, 32'hFFFF_FFFF, lat, err, rd, nrd, nwr);
    check("rsv_err", {31'b0, err}, 32'd1);
    check("rsv_lat", lat, 32'd1);
    check("rsv_nowrite", wr_count, wr_before);
    check("rsv_mem1", mem[1], 32'h0000_0002);

    // Word store then misaligned halfword/byte loads from mem[0]
    run_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h1234_5678, lat, err, rd, nrd, nwr);
    check("wstore_lat", lat, 32'd2);
    check("wstore_nrd", nrd, 32'd0);
    check("wstore_mem0", mem[0], 32'h1234_5678);
    run_req(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, lat, err, rd, nrd, nwr);
`ifdef MEM_ACCESS_MISALIGN_EN
    check("mis_h_err", {31'b0, err}, 32'd1);
    check("mis_h_nrd", nrd, 32'd0);
    check("mis_h_lat", lat, 32'd1);
`else
    check("mis_h_err", {31'b0, err}, 32'd0);
    check("mis_h_data", rd, 32'h0000_1234);
    check("mis_h_lat", lat, 32'd2);
`endif
    run_req(1'b0, 2'b00, 1'b1, 32'h3, 32'h0, lat, err, rd, nrd, nwr);
    check("sbload_b3", rd, 32'h0000_0012);

    // Reset landing in the WR cycle of a byte store to mem[2]
    wr_before = wr_count;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h9;
    bus.req_wdata  = 32'h0000_0077;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("rstwr_rd_phase", {31'b0, bus.mem_read_control}, 32'd1);
    @(posedge clk);
    #1;
    check("rstwr_wr_phase", {31'b0, bus.write_data_control}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstwr_wr_gated", {31'b0, bus.write_data_control}, 32'd0);
    @(posedge clk);
    #1;
    check("rstwr_no_done", {31'b0, bus.resp_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rstwr_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rstwr_no_done2", {31'b0, bus.resp_done}, 32'd0);
    check("rstwr_mem2", mem[2], 32'h8001_AB05);
    check("rstwr_nowrite", wr_count, wr_before);
    check("rstwr_rdata", bus.resp_rdata, 32'h0);

    run_req(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, lat, err, rd, nrd, nwr);
    check("post_rst_load", rd, 32'h0000_00AB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store unit between the CPU datapath and the word-indexed data memory (mem_data).
- Accepts one byte, halfword or word load/store request at a time.
- Converts the byte address to a word index and drives the memory's read/write controls.
- Performs read-modify-write for sub-word stores; returns aligned, sign- or zero-extended load data with a one-cycle done pulse.

Parameters:
- DEPTH, 128, number of 32-bit words in the data memory; word indices >= DEPTH are out of range.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle and able to accept; equals (state==IDLE).
- req_write  input  1  1=store, 0=load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_signed  input  1  loads only: 1 sign-extend, 0 zero-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_done  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; valid while resp_done=1, held until next done.
- resp_err  output  1  valid with resp_done; 1 = request rejected, no memory access made.
- mem_addr  output  32  word index = {2'b00, latched addr[31:2]}.
- mem_read_control  output  1  memory read enable.
- write_data_control  output  1  memory write enable; memory writes on the posedge where this is high.
- mem_wdata  output  32  full word to write.
- mem_rdata  input  32  combinational read data from memory.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, resp_done=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_read_control=0, write_data_control=0, mem_wdata=0.
- While rst=1, mem_read_control and write_data_control are forced 0 combinationally. A reset asserted in any state therefore never produces a memory write on that edge; the in-flight request is dropped with no done pulse.
- Byte lanes are little-endian: byte offset 0 = bits [7:0]; halfword offset 0 = bits [15:0], offset 2 = bits [31:16].
- Accept: in IDLE with req_valid=1, latch all req_* fields at the posedge. req_valid is ignored while req_ready=0.
- Error check at accept; on error go directly to DONE with resp_err=1. Errors are:
  - req_size=11
  - word index >= DEPTH
  - misalignment (see Optional Feature)
- State machine, legal requests:
  - IDLE -> RD for a load or a sub-word store.
  - IDLE -> WR for a word store.
- RD:
  - Drive mem_addr and mem_read_control=1.
  - Capture mem_rdata into the internal buffer at the posedge.
  - Next state: DONE for a load; WR for a sub-word store.
- WR:
  - Drive write_data_control=1 and mem_wdata.
  - Word store: mem_wdata = req_wdata.
  - Sub-word store: buffer with the addressed lane replaced by req_wdata[7:0] (byte) or [15:0] (halfword).
  - Next state: DONE.
- The unit never relies on the memory's write-bypass read path; reads and writes are in separate cycles.
- DONE:
  - resp_done=1 for exactly one cycle.
  - For a load, resp_rdata = extracted lane, extended per req_signed (word loads ignore req_signed).
  - Next state: IDLE.
- Latency from accept edge to resp_done cycle:
  - load or word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- Throughput: a new request may be accepted in the cycle after DONE (req_ready high again in IDLE).

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_EN.
- Defined: halfword with addr[0]=1, or word with addr[1:0]!=0, raises resp_err=1 with no memory access.
- Undefined: misalignment is not an error. Low address bits are forced aligned: halfword uses addr[1], word ignores addr[1:0]. The access proceeds normally.

Test Plan:
- Memory preloaded mem[1]=2, mem[2]=5. Word load addr 0x4 -> resp_done 2 cycles after accept, resp_rdata=0x00000002, resp_err=0, no write_data_control pulse.
- Byte store 0xAB to addr 0x9 -> RD then WR; write of 0x0000AB05 to mem_addr=2; done 3 cycles after accept. A following unsigned byte load at 0x9 returns 0x000000AB; signed returns 0xFFFFFFAB.
- Halfword store 0x8001 to addr 0xA, then signed halfword load at 0xA -> 0xFFFF8001. Word load at 0x8 -> 0x8001AB05.
- Word load at addr 0x200 (index 128) -> resp_done 1 cycle after accept with resp_err=1; mem_read_control stays 0.
- Halfword load at addr 0x3 -> with MEM_ACCESS_MISALIGN_EN: resp_err=1, no access. Without it: reads mem[0] lane [31:16], resp_err=0.
- Assert rst in the WR cycle of a byte store to addr 0x9 -> write_data_control=0 that cycle, mem[2] unchanged, no resp_done, req_ready=1 the cycle after reset deasserts.
